mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage: forwards non-memory results in one cycle, or runs a single data-memory
// transaction (read or write) with an ack timeout that returns a faulted writeback.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        IValid,
   input  logic        IRegWrite,
   input  logic        IMemWrite,
   input  logic        IMemRead,
   input  logic        IRegStore,
   input  logic [15:0] IALUResult,
   input  logic [15:0] I3rdArg,
   input  logic [15:0] IRd,
   output logic        MemReq,
   output logic        MemWe,
   output logic [15:0] MemAddr,
   output logic [15:0] MemWData,
   input  logic        MemAck,
   input  logic [15:0] MemRData,
   output logic        Stall,
   output logic        OValid,
   output logic        ORegWrite,
   output logic        ORegStore,
   output logic        OFault,
   output logic [15:0] OResult,
   output logic [15:0] ORd
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] rd_q, rd_d;
   logic        reg_write_q, reg_write_d;
   logic        reg_store_q, reg_store_d;
   logic        o_valid_q, o_valid_d;
   logic        o_reg_write_q, o_reg_write_d;
   logic        o_reg_store_q, o_reg_store_d;
   logic        o_fault_q, o_fault_d;
   logic [15:0] o_result_q, o_result_d;
   logic [15:0] o_rd_q, o_rd_d;
   logic        mem_op;
   logic        stall;

   assign mem_op = IMemRead | IMemWrite;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rd_d          = rd_q;
      reg_write_d   = reg_write_q;
      reg_store_d   = reg_store_q;
      o_valid_d     = 1'b0;
      o_fault_d     = 1'b0;
      o_reg_write_d = o_reg_write_q;
      o_reg_store_d = o_reg_store_q;
      o_result_d    = o_result_q;
      o_rd_d        = o_rd_q;
      stall         = 1'b0;
      case (state_q)
         IDLE: begin
            if (IValid && mem_op) begin
               stall       = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = IMemWrite;  // write wins when both bits are set
               mem_addr_d  = IALUResult;
               mem_wdata_d = I3rdArg;
               rd_d        = IRd;
               reg_write_d = IRegWrite;
               reg_store_d = IRegStore;
               cnt_d       = 8'd0;
               state_d     = ACCESS;
            end else if (IValid) begin
               o_valid_d     = 1'b1;
               o_result_d    = IALUResult;
               o_rd_d        = IRd;
               o_reg_write_d = IRegWrite;
               o_reg_store_d = IRegStore;
            end
         end
         ACCESS: begin
            stall = ~MemAck;
            if (MemAck) begin
               mem_req_d     = 1'b0;
               o_valid_d     = 1'b1;
               o_result_d    = mem_we_q ? mem_addr_q : MemRData;
               o_rd_d        = rd_q;
               o_reg_write_d = reg_write_q;
               o_reg_store_d = reg_store_q;
               state_d       = IDLE;
            end else if (cnt_q == TO_LAST) begin
               // Faulted op must not update the register file
               mem_req_d     = 1'b0;
               o_valid_d     = 1'b1;
               o_fault_d     = 1'b1;
               o_result_d    = 16'hFFFF;
               o_rd_d        = rd_q;
               o_reg_write_d = 1'b0;
               o_reg_store_d = 1'b0;
               state_d       = IDLE;
            end else begin
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 16'd0;
         mem_wdata_q   <= 16'd0;
         rd_q          <= 16'd0;
         reg_write_q   <= 1'b0;
         reg_store_q   <= 1'b0;
         o_valid_q     <= 1'b0;
         o_reg_write_q <= 1'b0;
         o_reg_store_q <= 1'b0;
         o_fault_q     <= 1'b0;
         o_result_q    <= 16'd0;
         o_rd_q        <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         rd_q          <= rd_d;
         reg_write_q   <= reg_write_d;
         reg_store_q   <= reg_store_d;
         o_valid_q     <= o_valid_d;
         o_reg_write_q <= o_reg_write_d;
         o_reg_store_q <= o_reg_store_d;
         o_fault_q     <= o_fault_d;
         o_result_q    <= o_result_d;
         o_rd_q        <= o_rd_d;
      end
   end

   assign MemReq    = mem_req_q;
   assign MemWe     = mem_we_q;
   assign MemAddr   = mem_addr_q;
   assign MemWData  = mem_wdata_q;
   assign Stall     = stall;
   assign OValid    = o_valid_q;
   assign ORegWrite = o_reg_write_q;
   assign ORegStore = o_reg_store_q;
   assign OFault    = o_fault_q;
   assign OResult   = o_result_q;
   assign ORd       = o_rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, load, store, timeout,
// mid-access reset and write-priority cases.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        IValid, IRegWrite, IMemWrite, IMemRead, IRegStore;
   logic [15:0] IALUResult, I3rdArg, IRd;
   logic        MemReq, MemWe, MemAck;
   logic [15:0] MemAddr, MemWData, MemRData;
   logic        Stall, OValid, ORegWrite, ORegStore, OFault;
   logic [15:0] OResult, ORd;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .Reset(Reset),
      .IValid(IValid), .IRegWrite(IRegWrite), .IMemWrite(IMemWrite),
      .IMemRead(IMemRead), .IRegStore(IRegStore),
      .IALUResult(IALUResult), .I3rdArg(I3rdArg), .IRd(IRd),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData),
      .Stall(Stall), .OValid(OValid), .ORegWrite(ORegWrite),
      .ORegStore(ORegStore), .OFault(OFault), .OResult(OResult), .ORd(ORd)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
      end else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one edge, then sample/drive 1 time unit later
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      IValid = 0; IRegWrite = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0;
      IALUResult = 16'h0; I3rdArg = 16'h0; IRd = 16'h0;
   endtask

   initial begin
      idle_inputs();
      MemAck = 0; MemRData = 16'h0;
      Reset = 1;
      #1;
      check("rst_memreq",  16'(MemReq),  16'h0);
      check("rst_ovalid",  16'(OValid),  16'h0);
      check("rst_oresult", OResult,      16'h0);
      check("rst_ord",     ORd,          16'h0);
      check("rst_stall",   16'(Stall),   16'h0);
      step(); step();
      Reset = 0;

      // non-memory op accepted at the first edge after reset
      IValid = 1; IALUResult = 16'h1234; IRd = 16'd3; IRegWrite = 1;
      #1 check("nm_stall", 16'(Stall), 16'h0);
      step();
      idle_inputs();
      check("nm_ovalid",  16'(OValid),    16'h1);
      check("nm_oresult", OResult,        16'h1234);
      check("nm_ord",     ORd,            16'd3);
      check("nm_oregwr",  16'(ORegWrite), 16'h1);
      check("nm_ofault",  16'(OFault),    16'h0);
      check("nm_memreq",  16'(MemReq),    16'h0);
      step();
      check("nm_pulse",   16'(OValid),    16'h0);
      check("nm_hold",    OResult,        16'h1234);

      // load: ack sampled at the third edge after MemReq rises
      IValid = 1; IMemRead = 1; IALUResult = 16'h0040; IRd = 16'd5; IRegWrite = 1;
      #1 check("ld_stall0", 16'(Stall), 16'h1);
      step();
      IValid = 1; IMemRead = 0; IALUResult = 16'hDEAD;
      #1;
      check("ld_memreq1", 16'(MemReq), 16'h1);
      check("ld_we",      16'(MemWe),  16'h0);
      check("ld_addr",    MemAddr,     16'h0040);
      check("ld_stall1",  16'(Stall),  16'h1);
      step();
      check("ld_memreq2", 16'(MemReq), 16'h1);
      check("ld_stall2",  16'(Stall),  16'h1);
      check("ld_addr2",   MemAddr,     16'h0040);
      step();
      idle_inputs();
      check("ld_memreq3", 16'(MemReq), 16'h1);
      MemAck = 1; MemRData = 16'hBEEF;
      #1 check("ld_stall3", 16'(Stall), 16'h0);
      step();
      MemAck = 0; MemRData = 16'h0;
      check("ld_memreq_off", 16'(MemReq), 16'h0);
      check("ld_ovalid",  16'(OValid),  16'h1);
      check("ld_oresult", OResult,      16'hBEEF);
      check("ld_ord",     ORd,          16'd5);
      check("ld_ofault",  16'(OFault),  16'h0);

      // store with zero-wait ack
      IValid = 1; IMemWrite = 1; IALUResult = 16'h0010; I3rdArg = 16'h00AA; IRd = 16'd7;
      step();
      idle_inputs();
      check("st_memreq", 16'(MemReq), 16'h1);
      check("st_we",     16'(MemWe),  16'h1);
      check("st_wdata",  MemWData,    16'h00AA);
      check("st_addr",   MemAddr,     16'h0010);
      MemAck = 1;
      #1 check("st_stall", 16'(Stall), 16'h0);
      step();
      MemAck = 0;
      check("st_memreq_off", 16'(MemReq), 16'h0);
      check("st_ovalid",  16'(OValid), 16'h1);
      check("st_oresult", OResult,     16'h0010);
      check("st_ord",     ORd,         16'd7);
      // next instruction presented right after completion
      IValid = 1; IALUResult = 16'h5555; IRd = 16'd9;
      step();
      idle_inputs();
      check("b2b_ovalid",  16'(OValid), 16'h1);
      check("b2b_oresult", OResult,     16'h5555);

      // timeout: four ACCESS cycles without ack
      IValid = 1; IMemRead = 1; IALUResult = 16'h0077; IRd = 16'd2; IRegWrite = 1;
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("to_memreq%0d", i), 16'(MemReq), 16'h1);
         check($sformatf("to_stall%0d", i),  16'(Stall),  16'h1);
         step();
      end
      check("to_memreq_off", 16'(MemReq),    16'h0);
      check("to_ovalid",     16'(OValid),    16'h1);
      check("to_ofault",     16'(OFault),    16'h1);
      check("to_oresult",    OResult,        16'hFFFF);
      check("to_oregwr",     16'(ORegWrite), 16'h0);
      check("to_stall_off",  16'(Stall),     16'h0);
      step();
      check("to_fault_pulse", 16'(OFault), 16'h0);
      check("to_valid_pulse", 16'(OValid), 16'h0);

      // reset during ACCESS drops MemReq without a clock edge
      IValid = 1; IMemRead = 1; IALUResult = 16'h0100; IRd = 16'd6;
      step();
      idle_inputs();
      check("rs_memreq1", 16'(MemReq), 16'h1);
      #2 Reset = 1;
      #1 check("rs_memreq_async", 16'(MemReq), 16'h0);
      step();
      check("rs_ovalid", 16'(OValid), 16'h0);
      Reset = 0;
      IValid = 1; IMemRead = 1; IALUResult = 16'h0200; IRd = 16'd4;
      #1 check("rs_ovalid2", 16'(OValid), 16'h0);
      step();
      idle_inputs();
      check("rs_memreq2", 16'(MemReq), 16'h1);
      check("rs_addr2",   MemAddr,     16'h0200);
      MemAck = 1; MemRData = 16'hCAFE;
      step();
      MemAck = 0;
      check("rs_ovalid3",  16'(OValid), 16'h1);
      check("rs_oresult3", OResult,     16'hCAFE);
      check("rs_ord3",     ORd,         16'd4);

      // read and write both set: treated as write
      IValid = 1; IMemRead = 1; IMemWrite = 1; IALUResult = 16'h0030; I3rdArg = 16'h0055;
      step();
      idle_inputs();
      check("rw_we",    16'(MemWe), 16'h1);
      check("rw_wdata", MemWData,   16'h0055);
      MemAck = 1; MemRData = 16'h9999;
      step();
      check("rw_ovalid",  16'(OValid), 16'h1);
      check("rw_oresult", OResult,     16'h0030);
      // spurious ack held into IDLE
      step();
      check("sp_ovalid", 16'(OValid), 16'h0);
      check("sp_memreq", 16'(MemReq), 16'h0);
      check("sp_hold",   OResult,     16'h0030);
      MemAck = 0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
